// File: rtl/core_boot_sequencer.sv
// Boot/run controller: packs an LE byte stream into 32-bit imem writes, then releases core reset.
// Latency: imem_we one cycle after the 4th byte of a word; core_resetn rises RST_HOLD cycles after the last write.
// Backpressure: s_ready only in LOAD/CHECK, gaps on s_valid stall; optional checksum word via BOOT_CHECKSUM_EN.
module core_boot_sequencer #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          RST_HOLD  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_words,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              halt_req,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_resetn,
    output logic              running,
    output logic              err,
    output logic [31:0]       run_cycles
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
`ifdef BOOT_CHECKSUM_EN
        CHECK   = 3'd5,
`endif
        RELEASE = 3'd2,
        RUN     = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_t              state;
    logic [ADDR_W:0]     word_cnt;
    logic [ADDR_W:0]     words_q;
    logic [1:0]          byte_idx;
    logic [23:0]         pack;
    logic [HOLD_W-1:0]   hold_cnt;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]         csum;
`endif

    logic        byte_fire;
    logic [31:0] full_word;

    assign byte_fire = s_valid && s_ready;
    assign full_word = {s_data, pack};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= BASE_ADDR;
            imem_wdata  <= 32'h0;
            core_resetn <= 1'b0;
            running     <= 1'b0;
            err         <= 1'b0;
            run_cycles  <= 32'h0;
            word_cnt    <= '0;
            words_q     <= '0;
            byte_idx    <= 2'd0;
            pack        <= 24'h0;
            hold_cnt    <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum        <= 32'h0;
`endif
        end else begin
            imem_we <= 1'b0;
            // Address steps past each written word, including the last one.
            if (imem_we) begin
                imem_addr <= imem_addr + 32'd4;
            end

            case (state)
                IDLE, HALT: begin
                    core_resetn <= 1'b0;
                    running     <= 1'b0;
                    s_ready     <= 1'b0;
                    if (load_start) begin
                        if (load_words > MAX_WORDS) begin
                            err <= 1'b1;
                        end else begin
                            err       <= 1'b0;
                            words_q   <= load_words;
                            word_cnt  <= '0;
                            byte_idx  <= 2'd0;
                            imem_addr <= BASE_ADDR;
`ifdef BOOT_CHECKSUM_EN
                            csum      <= 32'h0;
`endif
                            if (load_words == '0) begin
`ifdef BOOT_CHECKSUM_EN
                                state   <= CHECK;
                                s_ready <= 1'b1;
`else
                                state      <= RELEASE;
                                hold_cnt   <= '0;
                                run_cycles <= 32'h0;
`endif
                            end else begin
                                state   <= LOAD;
                                s_ready <= 1'b1;
                            end
                        end
                    end
                end

                LOAD: begin
                    if (byte_fire) begin
                        if (byte_idx != 2'd3) begin
                            case (byte_idx)
                                2'd0:    pack[7:0]   <= s_data;
                                2'd1:    pack[15:8]  <= s_data;
                                default: pack[23:16] <= s_data;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_wdata <= full_word;
                            byte_idx   <= 2'd0;
                            word_cnt   <= word_cnt + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                            csum       <= csum + full_word;
`endif
                            if (word_cnt == words_q - 1'b1) begin
                                s_ready <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                                state   <= CHECK;
`else
                                state      <= RELEASE;
                                hold_cnt   <= '0;
                                run_cycles <= 32'h0;
`endif
                            end
                        end
                    end
                end

`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    // Ready drops for the last data write, then reopens for the checksum word.
                    s_ready <= 1'b1;
                    if (byte_fire) begin
                        if (byte_idx != 2'd3) begin
                            case (byte_idx)
                                2'd0:    pack[7:0]   <= s_data;
                                2'd1:    pack[15:8]  <= s_data;
                                default: pack[23:16] <= s_data;
                            endcase
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            byte_idx <= 2'd0;
                            s_ready  <= 1'b0;
                            if (full_word == csum) begin
                                state      <= RELEASE;
                                hold_cnt   <= '0;
                                run_cycles <= 32'h0;
                            end else begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                end
`endif

                RELEASE: begin
                    core_resetn <= 1'b0;
                    s_ready     <= 1'b0;
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        core_resetn <= 1'b1;
                        running     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                RUN: begin
                    // Halt edge does not count as a run cycle.
                    if (halt_req) begin
                        state       <= HALT;
                        core_resetn <= 1'b0;
                        running     <= 1'b0;
                    end else if (run_cycles != 32'hFFFF_FFFF) begin
                        run_cycles <= run_cycles + 32'd1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    core_resetn <= 1'b0;
                    running     <= 1'b0;
                    s_ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_boot_sequencer.sv
// Directed bench for core_boot_sequencer: table of load scenarios plus hand-written reset/halt sequences.
module tb_core_boot_sequencer;

    localparam int ADDR_W   = 10;
    localparam int RST_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_words = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_data = 8'h0;
    logic              halt_req = 1'b0;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_resetn;
    logic              running;
    logic              err;
    logic [31:0]       run_cycles;

    core_boot_sequencer #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .RST_HOLD(RST_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_words  (load_words),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .halt_req    (halt_req),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_resetn (core_resetn),
        .running     (running),
        .err         (err),
        .run_cycles  (run_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    logic        wr_rdy[$];

    always @(negedge clk) begin
        if (!reset && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
            wr_rdy.push_back(s_ready);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        wr_rdy.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"},     {31'b0, s_ready},     32'h0);
        check({tag, "_imem_we"},     {31'b0, imem_we},     32'h0);
        check({tag, "_imem_addr"},   imem_addr,            32'h0);
        check({tag, "_imem_wdata"},  imem_wdata,           32'h0);
        check({tag, "_core_resetn"}, {31'b0, core_resetn}, 32'h0);
        check({tag, "_running"},     {31'b0, running},     32'h0);
        check({tag, "_err"},         {31'b0, err},         32'h0);
        check({tag, "_run_cycles"},  run_cycles,           32'h0);
    endtask

    task automatic start_load(input int n);
        load_words = (ADDR_W+1)'(n);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte_timeout: s_ready stayed 0, want 1");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic wait_resetn(output int rise_cyc);
        int t;
        t = 0;
        while (!core_resetn && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("resetn_rise_in_time", {31'b0, (t < 40)}, 32'h1);
        rise_cyc = cyc;
    endtask

    task automatic halt_core();
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
    endtask

    typedef struct {
        int          nwords;
        logic [7:0]  b[8];
        int          gap_after;
        int          gap_len;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise;
        int last;

        vecs[0] = '{2, '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, -1, 0, 32'h12345678, 32'hDEADBEEF};
        vecs[1] = '{2, '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE},  1, 3, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00},  2, 1, 32'h04030201, 32'h00000000};
        vecs[3] = '{2, '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44},  3, 2, 32'hFF00FF00, 32'h44332211};

        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // Table: load, release, run, halt; later rows reload from HALT.
        for (int i = 0; i < 4; i++) begin
            clear_log();
            start_load(vecs[i].nwords);
            check($sformatf("v%0d_ready_in_load", i), {31'b0, s_ready}, 32'h1);
            for (int k = 0; k < 4 * vecs[i].nwords; k++) begin
                send_byte(vecs[i].b[k]);
                if (k == vecs[i].gap_after) begin
                    s_valid = 1'b0;
                    repeat (vecs[i].gap_len) @(negedge clk);
                end
            end
`ifdef BOOT_CHECKSUM_EN
            send_word(vecs[i].w0 + vecs[i].w1);
`endif
            wait_resetn(rise);
            check($sformatf("v%0d_nwrites", i), wr_addr.size(), vecs[i].nwords);
            for (int j = 0; j < vecs[i].nwords && j < wr_addr.size(); j++) begin
                check($sformatf("v%0d_addr%0d", i, j), wr_addr[j], 32'(4 * j));
                check($sformatf("v%0d_data%0d", i, j), wr_data[j], (j == 0) ? vecs[i].w0 : vecs[i].w1);
            end
            if (wr_addr.size() > 0) begin
                last = wr_addr.size() - 1;
                check($sformatf("v%0d_ready_low_last_we", i), {31'b0, wr_rdy[last]}, 32'h0);
`ifndef BOOT_CHECKSUM_EN
                check($sformatf("v%0d_release_len", i), 32'(rise - wr_cyc[last]), 32'(RST_HOLD));
`endif
            end
            check($sformatf("v%0d_running", i), {31'b0, running}, 32'h1);
            halt_core();
            check($sformatf("v%0d_halt_resetn", i), {31'b0, core_resetn}, 32'h0);
            check($sformatf("v%0d_halt_running", i), {31'b0, running}, 32'h0);
        end

        // Async reset during the second word's write cycle.
        clear_log();
        start_load(3);
        for (int k = 0; k < 8; k++) send_byte(8'((k + 1) * 8'h11));
        check("prerst_we",    {31'b0, imem_we}, 32'h1);
        check("prerst_addr",  imem_addr,        32'h4);
        check("prerst_wdata", imem_wdata,       32'h88776655);
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("postrst_resetn", {31'b0, core_resetn}, 32'h0);
        check("postrst_ready",  {31'b0, s_ready},     32'h0);

        // Oversize rejected, exact depth accepted.
        start_load(2**ADDR_W + 1);
        check("big_err",   {31'b0, err},     32'h1);
        check("big_ready", {31'b0, s_ready}, 32'h0);
        repeat (3) @(negedge clk);
        check("big_ready_later",  {31'b0, s_ready},     32'h0);
        check("big_resetn_later", {31'b0, core_resetn}, 32'h0);
        start_load(2**ADDR_W);
        check("max_err_cleared", {31'b0, err},     32'h0);
        check("max_ready",       {31'b0, s_ready}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero-word load, ignored load_start in RUN, 100 run cycles, halt.
        clear_log();
        start_load(0);
`ifdef BOOT_CHECKSUM_EN
        send_word(32'h0);
`endif
        wait_resetn(rise);
        check("zero_nwrites", wr_addr.size(), 0);
        check("run_start_cycles", run_cycles, 32'h0);
        start_load(5);
        check("run_ignore_load_running", {31'b0, running}, 32'h1);
        check("run_ignore_load_ready",   {31'b0, s_ready}, 32'h0);
        check("run_cycles_1", run_cycles, 32'd1);
        repeat (99) @(negedge clk);
        check("run_cycles_100", run_cycles, 32'd100);
        halt_core();
        check("halt100_resetn",  {31'b0, core_resetn}, 32'h0);
        check("halt100_running", {31'b0, running},     32'h0);
        check("halt100_cycles",  run_cycles,           32'd100);
        repeat (5) @(negedge clk);
        check("halt100_held",        run_cycles,           32'd100);
        check("halt100_resetn_held", {31'b0, core_resetn}, 32'h0);

`ifndef BOOT_CHECKSUM_EN
        // halt_req coincident with RELEASE->RUN: RUN first, halt one cycle later.
        start_load(0);
        repeat (RST_HOLD - 1) @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        check("coinc_running", {31'b0, running}, 32'h1);
        @(negedge clk);
        halt_req = 1'b0;
        check("coinc_halt_resetn", {31'b0, core_resetn}, 32'h0);
        check("coinc_halt_cycles", run_cycles,           32'h0);
`else
        // Checksum: good word releases, bad word errors back to IDLE.
        start_load(2);
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd3);
        wait_resetn(rise);
        check("csum_ok_running", {31'b0, running}, 32'h1);
        check("csum_ok_err",     {31'b0, err},     32'h0);
        halt_core();
        start_load(2);
        send_word(32'd1);
        send_word(32'd2);
        send_word(32'd4);
        check("csum_bad_err", {31'b0, err}, 32'h1);
        repeat (RST_HOLD + 2) @(negedge clk);
        check("csum_bad_resetn", {31'b0, core_resetn}, 32'h0);
        check("csum_bad_ready",  {31'b0, s_ready},     32'h0);
        start_load(0);
        check("csum_err_cleared", {31'b0, err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
